// File: rtl/scmp_agu_if.sv
// scmp_agu_if: sequencer <-> AGU request/result bundle
interface scmp_agu_if #(
  parameter int ADDR_W = 16,
  parameter int PSEL_W = 2
);
  logic              req;
  logic [2:0]        op;
  logic [PSEL_W-1:0] ptr_sel;
  logic [7:0]        disp;
  logic [7:0]        ext;
  logic [ADDR_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] ea;
  logic [ADDR_W-1:0] rdata;
  logic [ADDR_W-1:0] pc;
  modport master (output req, op, ptr_sel, disp, ext, wdata, input busy, done, ea, rdata, pc);
  modport slave  (input req, op, ptr_sel, disp, ext, wdata, output busy, done, ea, rdata, pc);
endinterface

// File: rtl/scmp_agu.sv
// scmp_agu: SC/MP pointer bank and two-step page-wrapping effective address unit
module scmp_agu #(
  parameter int NPTR   = 4,
  parameter int ADDR_W = 16,
  parameter int PAGE_W = 12,
  parameter int PSEL_W = $clog2(NPTR)
) (
  input logic       clk,
  input logic       rst_n,
  scmp_agu_if.slave bus
);
  localparam logic [2:0] OP_NOP = 3'd0, OP_LD = 3'd1, OP_EA = 3'd2, OP_AUTO = 3'd3, OP_INC = 3'd4, OP_XCH = 3'd5;
  localparam int NSEL = 1 << PSEL_W;
  localparam logic [NSEL-1:0] SEL_OK = NSEL'((64'd1 << NPTR) - 64'd1);
  localparam logic [ADDR_W-1:0] PMASK = ADDR_W'((64'd1 << PAGE_W) - 64'd1);
  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI} state_t;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_ptr [NPTR];
  logic [2:0]        r_op;
  logic [PSEL_W-1:0] r_sel;
  logic [7:0]        r_d;
  logic [ADDR_W-1:0] r_wdata;
  logic [7:0]        r_lo;
  logic              r_c;
  logic              r_done;
  logic [ADDR_W-1:0] r_ea, r_rdata;
  logic [ADDR_W-1:0] w_p, w_sum, w_new, w_ea, w_rd;
  logic [ADDR_W-9:0] w_hi;
  logic [8:0]        w_lo;
  logic              w_wr;
  assign w_p  = r_ptr[r_sel];
  assign w_lo = {1'b0, w_p[7:0]} + {1'b0, r_d};
  // sign of d supplies the borrow (all-ones) into the high step
  assign w_hi  = w_p[ADDR_W-1:8] + {(ADDR_W-8){r_d[7]}} + (ADDR_W-8)'(r_c);
  assign w_sum = (w_p & ~PMASK) | ({w_hi, r_lo} & PMASK);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_wr   = 1'b0;
    w_new  = w_sum;
    w_ea   = w_sum;
    w_rd   = w_sum;
    w_next = r_state == S_IDLE ? (bus.req ? S_LO : S_IDLE) : r_state == S_LO ? S_HI : S_IDLE;
    w_wr   = r_op == OP_LD || r_op == OP_AUTO || r_op == OP_INC || r_op == OP_XCH;
    w_new  = (r_op == OP_LD || r_op == OP_XCH) ? r_wdata : w_sum;
    w_ea   = r_op == OP_LD ? r_wdata : (r_op == OP_XCH || (r_op == OP_AUTO && !r_d[7])) ? w_p : w_sum;
    w_rd   = r_op == OP_LD ? r_wdata : (r_op == OP_EA || r_op == OP_XCH) ? w_p : w_sum;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ptr   <= '{default: '0};
      r_op    <= OP_NOP;
      r_sel   <= '0;
      r_d     <= '0;
      r_wdata <= '0;
      r_lo    <= '0;
      r_c     <= 1'b0;
      r_done  <= 1'b0;
      r_ea    <= '0;
      r_rdata <= '0;
    end else begin
      r_done <= r_state == S_HI;
      if (r_state == S_IDLE && bus.req) begin
        r_op    <= (bus.op > OP_XCH || !SEL_OK[bus.ptr_sel]) ? OP_NOP : bus.op;
        r_sel   <= SEL_OK[bus.ptr_sel] ? bus.ptr_sel : '0;
        r_d     <= bus.op == OP_INC ? 8'd1 : bus.disp == 8'h80 ? bus.ext : bus.disp;
        r_wdata <= bus.wdata;
      end
      if (r_state == S_LO) begin
        r_lo <= w_lo[7:0];
        r_c  <= w_lo[8];
      end
      if (r_state == S_HI) begin
        if (w_wr) r_ptr[r_sel] <= w_new;
        if (r_op != OP_NOP) begin
          r_ea    <= w_ea;
          r_rdata <= w_rd;
        end
      end
    end
  assign bus.busy  = r_state != S_IDLE;
  assign bus.done  = r_done;
  assign bus.ea    = r_ea;
  assign bus.rdata = r_rdata;
  assign bus.pc    = r_ptr[0];
endmodule

// File: tb/tb_scmp_agu.sv
// tb_scmp_agu: directed scoreboard bench for scmp_agu (16/12-bit bank plus a 12-bit full-page instance)
module tb_scmp_agu;
  localparam logic [2:0] OP_NOP = 3'd0, OP_LD = 3'd1, OP_EA = 3'd2, OP_AUTO = 3'd3, OP_INC = 3'd4, OP_XCH = 3'd5;
  typedef struct {logic [15:0] ea; logic [15:0] rd; string nm;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  exp_t sb[$];
  always #5 clk = ~clk;
  scmp_agu_if #(.ADDR_W(16), .PSEL_W(2)) bus ();
  scmp_agu #(.NPTR(4), .ADDR_W(16), .PAGE_W(12)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  scmp_agu_if #(.ADDR_W(12), .PSEL_W(3)) bus2 ();
  scmp_agu #(.NPTR(8), .ADDR_W(12), .PAGE_W(12)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  task automatic check(string nm, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected none (ea %h)", bus.ea);
      end else begin
        e = sb.pop_front();
        check({e.nm, "_ea"}, bus.ea, e.ea);
        check({e.nm, "_rd"}, bus.rdata, e.rd);
      end
    end
  end
  // starts at a negedge with the DUT idle or in its done cycle; returns at the negedge of the done cycle
  task automatic issue(string nm, logic [2:0] op, logic [1:0] sel, logic [7:0] d, logic [7:0] x,
                       logic [15:0] wd, logic [15:0] eea, logic [15:0] erd, bit glitch = 1'b0);
    int lat = 0;
    int nb = 0;
    bus.req = 1'b1; bus.op = op; bus.ptr_sel = sel; bus.disp = d; bus.ext = x; bus.wdata = wd;
    sb.push_back('{eea, erd, nm});
    @(posedge clk);
    #1 bus.req = 1'b0;
    while (lat < 10 && !bus.done) begin
      @(negedge clk);
      lat++;
      if (bus.busy) nb++;
      if (glitch && lat == 1) begin
        bus.req = 1'b1; bus.op = OP_LD; bus.wdata = 16'hFFFF;
      end
      if (glitch && lat == 2) bus.req = 1'b0;
    end
    check({nm, "_lat"}, 16'(lat), 16'd3);
    check({nm, "_busy"}, 16'(nb), 16'd2);
  endtask
  task automatic issue2(string nm, logic [2:0] op, logic [11:0] wd, logic [11:0] eea);
    int lat = 0;
    bus2.req = 1'b1; bus2.op = op; bus2.ptr_sel = 3'd0; bus2.disp = 8'h00; bus2.ext = 8'h00; bus2.wdata = wd;
    @(posedge clk);
    #1 bus2.req = 1'b0;
    while (lat < 10 && !bus2.done) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_lat"}, 16'(lat), 16'd3);
    check({nm, "_ea"}, 16'(bus2.ea), 16'(eea));
  endtask
  initial begin
    bus.req = 1'b0; bus.op = OP_NOP; bus.ptr_sel = '0; bus.disp = '0; bus.ext = '0; bus.wdata = '0;
    bus2.req = 1'b0; bus2.op = OP_NOP; bus2.ptr_sel = '0; bus2.disp = '0; bus2.ext = '0; bus2.wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ea", bus.ea, 16'h0);
    check("rst_rdata", bus.rdata, 16'h0);
    check("rst_pc", bus.pc, 16'h0);
    check("rst_busy", 16'(bus.busy), 16'h0);
    check("rst_done", 16'(bus.done), 16'h0);
    rst_n = 1'b1;
    @(negedge clk);
    issue("ld_p1", OP_LD, 2'd1, 8'h00, 8'h00, 16'h2345, 16'h2345, 16'h2345);
    issue("ld_p0", OP_LD, 2'd0, 8'h00, 8'h00, 16'h1FFF, 16'h1FFF, 16'h1FFF);
    check("pc_ld", bus.pc, 16'h1FFF);
    issue("inc_wrap", OP_INC, 2'd0, 8'h7F, 8'h00, 16'h0, 16'h1000, 16'h1000);
    check("pc_wrap", bus.pc, 16'h1000);
    issue("ld_p0b", OP_LD, 2'd0, 8'h00, 8'h00, 16'h10FF, 16'h10FF, 16'h10FF);
    issue("inc_carry", OP_INC, 2'd0, 8'h00, 8'h00, 16'h0, 16'h1100, 16'h1100);
    check("pc_carry", bus.pc, 16'h1100);
    issue("ld_p2", OP_LD, 2'd2, 8'h00, 8'h00, 16'h3010, 16'h3010, 16'h3010);
    issue("ea_neg", OP_EA, 2'd2, 8'hF0, 8'h00, 16'h0, 16'h3000, 16'h3010);
    issue("ea_ext", OP_EA, 2'd2, 8'h80, 8'h05, 16'h0, 16'h3015, 16'h3010);
    issue("ld_p3", OP_LD, 2'd3, 8'h00, 8'h00, 16'h0400, 16'h0400, 16'h0400);
    issue("auto_neg", OP_AUTO, 2'd3, 8'hFF, 8'h00, 16'h0, 16'h03FF, 16'h03FF);
    issue("auto_pos", OP_AUTO, 2'd3, 8'h02, 8'h00, 16'h0, 16'h03FF, 16'h0401);
    issue("rd_p3", OP_EA, 2'd3, 8'h00, 8'h00, 16'h0, 16'h0401, 16'h0401);
    issue("xch_p1", OP_XCH, 2'd1, 8'h00, 8'h00, 16'h0ABC, 16'h2345, 16'h2345, 1'b1);
    issue("rd_p1", OP_EA, 2'd1, 8'h00, 8'h00, 16'h0, 16'h0ABC, 16'h0ABC);
    issue("nop6", 3'd6, 2'd1, 8'h00, 8'h00, 16'h5555, 16'h0ABC, 16'h0ABC);
    check("pc_after_nop", bus.pc, 16'h1100);
    @(negedge clk);
    bus.req = 1'b1; bus.op = OP_LD; bus.ptr_sel = 2'd1; bus.wdata = 16'h7777;
    @(posedge clk);
    #1 bus.req = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy_hi", 16'(bus.busy), 16'h1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 16'(bus.busy), 16'h0);
    check("abort_done", 16'(bus.done), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_pc", bus.pc, 16'h0);
    issue("abort_p1", OP_EA, 2'd1, 8'h00, 8'h00, 16'h0, 16'h0000, 16'h0000);
    @(negedge clk);
    issue2("w_ld", OP_LD, 12'hFFF, 12'hFFF);
    check("w_pc_ld", 16'(bus2.pc), 16'h0FFF);
    issue2("w_inc", OP_INC, 12'h000, 12'h000);
    check("w_pc_inc", 16'(bus2.pc), 16'h0000);
    repeat (3) @(negedge clk);
    check("sb_drain", 16'(sb.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
